// File: rtl/alu_exec_if.sv
// Handshake bundle for alu_exec_unit: an operation channel (valid/ready with
// control code and operands) and a result channel (valid/ready with result,
// zero and illegal flags).
interface alu_exec_if #(
   parameter int N = 64
);
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   alucontrol;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         zero;
   logic         illegal;

   modport master (
      output in_valid, alucontrol, a, b, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, alucontrol, a, b, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts a 4-bit control code and two operands, computes
// AND/OR/ADD/SUB, and returns result/zero/illegal through a single registered
// output stage with back-pressure. Illegal codes complete normally with a zero
// result and are counted in a saturating error counter.
module alu_exec_unit #(
   parameter int N    = 64,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            reset,
   alu_exec_if.slave       bus,
   input  logic            clr_err,
   output logic [CNTW-1:0] err_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t       state;
   state_t       state_n;
   logic         accept;
   logic         consumed;
   logic [N-1:0] op_result;
   logic         op_illegal;
   logic [N-1:0] result_q;
   logic         zero_q;
   logic         illegal_q;

   assign bus.in_ready  = (state == EMPTY) | bus.out_ready;
   assign accept        = bus.in_valid & bus.in_ready;
   assign consumed      = (state == FULL) & bus.out_ready;
   assign bus.out_valid = (state == FULL);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.illegal   = illegal_q;

   // Decode the control code and evaluate the operation.
   always_comb begin
      op_result  = '0;
      op_illegal = 1'b0;
      case (bus.alucontrol)
         4'b0000: op_result = bus.a & bus.b;
         4'b0001: op_result = bus.a | bus.b;
         4'b0010: op_result = bus.a + bus.b;
         4'b0110: op_result = bus.a - bus.b;
         default: op_illegal = 1'b1;
      endcase
   end

   // Next-state logic for the output register occupancy.
   always_comb begin
      state_n = state;
      case (state)
         EMPTY:   if (accept) state_n = FULL;
         FULL:    if (consumed && !accept) state_n = EMPTY;
         default: state_n = EMPTY;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= EMPTY;
      else        state <= state_n;
   end

   // Output register: loads on every accept, otherwise holds.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else if (accept) begin
         result_q  <= op_result;
         zero_q    <= (op_result == '0);
         illegal_q <= op_illegal;
      end
   end

   // Saturating illegal-op counter; a clear in the same cycle as an illegal
   // accept leaves a count of one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= (accept && op_illegal) ? CNTW'(1) : '0;
      end else if (accept && op_illegal && (err_count != '1)) begin
         err_count <= err_count + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed literal cases plus random
// traffic against a queue-based transaction model. A second instance with a
// 2-bit error counter shares the stimulus to exercise saturation.
module tb_alu_exec_unit;

   typedef struct {
      logic [63:0] r;
      logic        z;
      logic        il;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] err_count;
   logic [1:0] err2;

   int   n_vec = 0;
   int   n_miss = 0;
   exp_t q[$];
   int   cnt = 0;
   int   cnt2 = 0;
   bit   chk_en = 1'b0;

   alu_exec_if #(.N(64)) bus ();
   alu_exec_if #(.N(64)) bus2 ();

   alu_exec_unit #(.N(64), .CNTW(8)) dut (
      .clk(clk), .reset(rst_n), .bus(bus.slave), .clr_err(clr_err), .err_count(err_count)
   );

   alu_exec_unit #(.N(64), .CNTW(2)) dut2 (
      .clk(clk), .reset(rst_n), .bus(bus2.slave), .clr_err(clr_err), .err_count(err2)
   );

   assign bus2.in_valid   = bus.in_valid;
   assign bus2.alucontrol = bus.alucontrol;
   assign bus2.a          = bus.a;
   assign bus2.b          = bus.b;
   assign bus2.out_ready  = bus.out_ready;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      e.il = 1'b0;
      case (op)
         4'h0:    e.r = a & b;
         4'h1:    e.r = a | b;
         4'h2:    e.r = a + b;
         4'h6:    e.r = a - b;
         default: begin e.r = 64'h0; e.il = 1'b1; end
      endcase
      e.z = (e.r == 64'h0);
      return e;
   endfunction

   task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic ordy);
      bus.in_valid   = v;
      bus.alucontrol = op;
      bus.a          = a;
      bus.b          = b;
      bus.out_ready  = ordy;
   endtask

   // One clock: evaluate the model from the inputs presented, advance at the edge.
   task automatic tick();
      bit   acc = 1'b0;
      bit   cons = 1'b0;
      bit   rst_ok;
      exp_t e;
      rst_ok = rst_n;
      e = model_op(bus.alucontrol, bus.a, bus.b);
      if (rst_ok) begin
         cons = (q.size() != 0) && bus.out_ready;
         acc  = bus.in_valid && ((q.size() == 0) || bus.out_ready);
      end
      @(posedge clk);
      if (rst_ok && rst_n) begin
         if (cons) void'(q.pop_front());
         if (acc) q.push_back(e);
         if (clr_err) begin
            cnt  = (acc && e.il) ? 1 : 0;
            cnt2 = cnt;
         end else if (acc && e.il) begin
            if (cnt < 255) cnt++;
            if (cnt2 < 3) cnt2++;
         end
      end
      #1;
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", {63'h0, bus.in_ready}, {63'h0, (q.size() == 0) || bus.out_ready});
         check("out_valid", {63'h0, bus.out_valid}, {63'h0, q.size() != 0});
         check("out_valid2", {63'h0, bus2.out_valid}, {63'h0, q.size() != 0});
         check("in_ready2", {63'h0, bus2.in_ready}, {63'h0, (q.size() == 0) || bus.out_ready});
         if (q.size() != 0) begin
            check("result", bus.result, q[0].r);
            check("zero", {63'h0, bus.zero}, {63'h0, q[0].z});
            check("illegal", {63'h0, bus.illegal}, {63'h0, q[0].il});
            check("result2", bus2.result, q[0].r);
         end
         check("err_count", {56'h0, err_count}, 64'(cnt));
         check("err_count_sat", {62'h0, err2}, 64'(cnt2));
      end
   end

   initial begin
      drive(1'b0, 4'h0, 64'h0, 64'h0, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      check("reset_out_valid", {63'h0, bus.out_valid}, 64'h0);
      check("reset_err", {56'h0, err_count}, 64'h0);
      check("reset_result", bus.result, 64'h0);

      // Arithmetic wrap and two's complement subtraction.
      drive(1'b1, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
      tick();
      check("add_wrap_result", bus.result, 64'h0);
      check("add_wrap_zero", {63'h0, bus.zero}, 64'h1);
      check("add_wrap_illegal", {63'h0, bus.illegal}, 64'h0);
      check("add_wrap_valid", {63'h0, bus.out_valid}, 64'h1);
      drive(1'b1, 4'b0110, 64'h5, 64'h7, 1'b1);
      tick();
      check("sub_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
      check("sub_zero", {63'h0, bus.zero}, 64'h0);

      // Logic ops back to back.
      drive(1'b1, 4'b0000, 64'hF0, 64'h3C, 1'b1);
      tick();
      check("and_result", bus.result, 64'h30);
      check("and_in_ready", {63'h0, bus.in_ready}, 64'h1);
      drive(1'b1, 4'b0001, 64'hF0, 64'h0F, 1'b1);
      tick();
      check("or_result", bus.result, 64'hFF);

      // Back-pressure with a queued op.
      drive(1'b1, 4'b0010, 64'h1, 64'h2, 1'b0);
      repeat (3) begin
         tick();
         check("bp_in_ready", {63'h0, bus.in_ready}, 64'h0);
         check("bp_hold", bus.result, 64'hFF);
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_reload", bus.result, 64'h3);
      check("bp_valid", {63'h0, bus.out_valid}, 64'h1);
      bus.in_valid = 1'b0;
      tick();
      check("bp_drain", {63'h0, bus.out_valid}, 64'h0);

      // Illegal codes and counter saturation on the narrow instance.
      drive(1'b1, 4'b1111, 64'h1, 64'h2, 1'b1);
      tick();
      check("ill_f_flag", {63'h0, bus.illegal}, 64'h1);
      check("ill_f_result", bus.result, 64'h0);
      check("ill_f_zero", {63'h0, bus.zero}, 64'h1);
      drive(1'b1, 4'b0101, 64'h9, 64'h3, 1'b1);
      tick();
      check("ill_5_flag", {63'h0, bus.illegal}, 64'h1);
      bus.in_valid = 1'b0;
      tick();
      check("ill_count2", {56'h0, err_count}, 64'h2);
      repeat (3) begin
         drive(1'b1, 4'b1111, 64'h0, 64'h0, 1'b1);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      check("ill_count5", {56'h0, err_count}, 64'h5);
      check("ill_sat", {62'h0, err2}, 64'h3);

      // Clear coinciding with an illegal accept, then clear alone.
      drive(1'b1, 4'b1111, 64'h0, 64'h0, 1'b1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_with_ill", {56'h0, err_count}, 64'h1);
      bus.in_valid = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_alone", {56'h0, err_count}, 64'h0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         logic [3:0] op;
         case ($urandom_range(0, 4))
            0: op = 4'b0000;
            1: op = 4'b0001;
            2: op = 4'b0010;
            3: op = 4'b0110;
            default: op = 4'($urandom);
         endcase
         drive($urandom_range(0, 3) != 0, op,
               ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
               $urandom_range(0, 3) != 0);
         clr_err = ($urandom_range(0, 29) == 0);
         tick();
      end
      clr_err = 1'b0;

      // Asynchronous reset while holding an unconsumed op.
      drive(1'b1, 4'b1111, 64'h0, 64'h0, 1'b0);
      tick();
      tick();
      #2 rst_n = 1'b0;
      q.delete();
      cnt  = 0;
      cnt2 = 0;
      #1;
      check("async_rst_valid", {63'h0, bus.out_valid}, 64'h0);
      check("async_rst_err", {56'h0, err_count}, 64'h0);
      bus.in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) begin
         tick();
         check("post_rst_idle", {63'h0, bus.out_valid}, 64'h0);
      end
      drive(1'b1, 4'b0010, 64'h10, 64'h20, 1'b1);
      tick();
      check("post_rst_accept", bus.result, 64'h30);
      bus.in_valid = 1'b0;
      tick();
      @(negedge clk);
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
